retire_trace_buf: RTL and testbench



---
 rtl/retire_trace_buf_pkg.sv | 33 +++
 rtl/retire_trace_buf_if.sv | 55 +++++
 rtl/retire_trace_buf_fifo.sv | 67 ++++++
 rtl/retire_trace_buf.sv | 139 +++++++++++++
 tb/tb_retire_trace_buf.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/retire_trace_buf_pkg.sv
// Shared types for the retire-event trace monitor.
// Default-width entry layout, event classes and monitor states.
package trace_pkg;

  localparam int TR_DATA_W = 16;
  localparam int TR_REG_W  = 3;
  localparam int TR_CNT_W  = 32;

  typedef enum logic [2:0] {
    T_ALU   = 3'd0,
    T_LOAD  = 3'd1,
    T_STORE = 3'd2,
    T_HALT  = 3'd3,
    T_NOP   = 3'd4
  } trace_type_e;

  typedef struct packed {
    trace_type_e           typ;
    logic [TR_CNT_W-1:0]   inum;
    logic [TR_DATA_W-1:0]  pc;
    logic [TR_REG_W-1:0]   rd;
    logic [TR_DATA_W-1:0]  value;
    logic [TR_DATA_W-1:0]  addr;
  } trace_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } mon_state_e;

endpackage

// File: rtl/retire_trace_buf_if.sv
// Tap, drain-port and status bundle of the trace monitor.
// master = CPU/debug-host side, slave = monitor side.
interface retire_trace_buf_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              en;
  logic [DATA_W-1:0] pc;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              halt;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [2:0]        rd_type;
  logic [CNT_W-1:0]  rd_inum;
  logic [DATA_W-1:0] rd_pc;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_value;
  logic [DATA_W-1:0] rd_addr;

  logic [CNT_W-1:0]  inst_count;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  drop_count;
  logic [LVL_W-1:0]  level;
  logic              halted;
  logic              timeout;
  logic              overflow;

  modport master (
    output en, pc, reg_write, mem_read, mem_write, halt,
    output rd, wr_data, mem_addr, mem_data, rd_ready,
    input  rd_valid, rd_type, rd_inum, rd_pc, rd_reg,
    input  rd_value, rd_addr, inst_count, cycle_count,
    input  drop_count, level, halted, timeout, overflow
  );

  modport slave (
    input  en, pc, reg_write, mem_read, mem_write, halt,
    input  rd, wr_data, mem_addr, mem_data, rd_ready,
    output rd_valid, rd_type, rd_inum, rd_pc, rd_reg,
    output rd_value, rd_addr, inst_count, cycle_count,
    output drop_count, level, halted, timeout, overflow
  );

endinterface

// File: rtl/retire_trace_buf_fifo.sv
// Circular trace buffer with overwrite-oldest or drop-newest on full.
// Head fields read as zero while the buffer is empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH     = 16,
  parameter int  OVERWRITE = 1,
  parameter type entry_t   = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  entry_t                 entry_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   lost_o,
  output logic                   drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full, pop, wr, adv;

  assign valid_o = level_q != '0;
  assign full    = level_q == LW'(DEPTH);
  assign pop     = pop_i && valid_o;
  assign lost_o  = push_i && full && !pop;
  assign drop_o  = lost_o && (OVERWRITE == 0);
  assign wr      = push_i && !drop_o;
  // A full overwrite writes onto the oldest slot and skips past it
  assign adv     = pop || (lost_o && (OVERWRITE != 0));
  assign head_o  = valid_o ? mem_q[head_q] : '0;
  assign level_o = level_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (adv) head_d = head_q + AW'(1);
    if (wr)  tail_d = tail_q + AW'(1);
    if (wr && !adv)      level_d = level_q + LW'(1);
    else if (adv && !wr) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[tail_q] <= entry_i;
  end

endmodule

// File: rtl/retire_trace_buf.sv
// Retire-event monitor: classifies writeback/memory strobes, numbers
// events, buffers them for a debug host and keeps run statistics.
module retire_trace_buf
  import trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 3,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int WDOG_LIMIT  = 100000,
  parameter int OVERWRITE   = 1,
  parameter int CAPTURE_NOP = 1
) (
  input  logic              clk,
  input  logic              rst,
  retire_trace_buf_if.slave bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    trace_type_e       typ;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } entry_t;

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  entry_t           ev, head;
  logic             capture, counted;
  logic             fifo_valid, fifo_lost, fifo_drop;
  logic [LVL_W-1:0] level;

  always_comb begin
    ev      = '0;
    ev.typ  = T_NOP;
    ev.pc   = bus.pc;
    ev.inum = inst_q;
    priority case (1'b1)
      bus.reg_write && bus.mem_read: begin
        ev.typ   = T_LOAD;
        ev.rd    = bus.rd;
        ev.value = bus.wr_data;
        ev.addr  = bus.mem_addr;
      end
      bus.reg_write: begin
        ev.typ   = T_ALU;
        ev.rd    = bus.rd;
        ev.value = bus.wr_data;
      end
      bus.halt: ev.typ = T_HALT;
      bus.mem_write: begin
        ev.typ   = T_STORE;
        ev.value = bus.mem_data;
        ev.addr  = bus.mem_addr;
      end
      default: ev.typ = T_NOP;
    endcase
  end

  assign capture = (state_q == S_RUN) && bus.en;
  assign counted = capture &&
                   ((ev.typ != T_NOP) || (CAPTURE_NOP != 0));

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cyc_d   = cyc_q;
    drop_d  = drop_q + CNT_W'(fifo_drop);
    ovf_d   = ovf_q | fifo_lost;
    if (capture) cyc_d = cyc_q + CNT_W'(1);
    if (counted) inst_d = inst_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: if (bus.en) state_d = S_RUN;
      S_RUN: begin
        if (capture && ev.typ == T_HALT)
          state_d = S_HALTED;
        else if (capture && cyc_d == CNT_W'(WDOG_LIMIT))
          state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      cyc_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cyc_q   <= cyc_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE),
    .entry_t   (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (counted),
    .entry_i (ev),
    .pop_i   (bus.rd_ready),
    .valid_o (fifo_valid),
    .head_o  (head),
    .level_o (level),
    .lost_o  (fifo_lost),
    .drop_o  (fifo_drop)
  );

  assign bus.rd_valid    = fifo_valid;
  assign bus.rd_type     = head.typ;
  assign bus.rd_inum     = head.inum;
  assign bus.rd_pc       = head.pc;
  assign bus.rd_reg      = head.rd;
  assign bus.rd_value    = head.value;
  assign bus.rd_addr     = head.addr;
  assign bus.inst_count  = inst_q;
  assign bus.cycle_count = cyc_q;
  assign bus.drop_count  = drop_q;
  assign bus.level       = level;
  assign bus.halted      = state_q == S_HALTED;
  assign bus.timeout     = state_q == S_TIMEOUT;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Bench: three monitor configurations share one stimulus stream and
// are each compared against a queue-based model of the trace rules.
module tb_retire_trace_buf;

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [2:0]  rg;
    logic [15:0] val;
    logic [15:0] addr;
  } ment_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en, reg_write, mem_read, mem_write, halt, rd_ready;
  logic [15:0] pc, wr_data, mem_addr, mem_data;
  logic [2:0]  rd;

  retire_trace_buf_if #(.DEPTH(4))  ifa ();
  retire_trace_buf_if #(.DEPTH(4))  ifb ();
  retire_trace_buf_if #(.DEPTH(16)) ifc ();

  assign ifa.en = en;  assign ifb.en = en;  assign ifc.en = en;
  assign ifa.pc = pc;  assign ifb.pc = pc;  assign ifc.pc = pc;
  assign ifa.rd = rd;  assign ifb.rd = rd;  assign ifc.rd = rd;
  assign ifa.reg_write = reg_write;
  assign ifb.reg_write = reg_write;
  assign ifc.reg_write = reg_write;
  assign ifa.mem_read = mem_read;
  assign ifb.mem_read = mem_read;
  assign ifc.mem_read = mem_read;
  assign ifa.mem_write = mem_write;
  assign ifb.mem_write = mem_write;
  assign ifc.mem_write = mem_write;
  assign ifa.halt = halt;  assign ifb.halt = halt;  assign ifc.halt = halt;
  assign ifa.wr_data = wr_data;
  assign ifb.wr_data = wr_data;
  assign ifc.wr_data = wr_data;
  assign ifa.mem_addr = mem_addr;
  assign ifb.mem_addr = mem_addr;
  assign ifc.mem_addr = mem_addr;
  assign ifa.mem_data = mem_data;
  assign ifb.mem_data = mem_data;
  assign ifc.mem_data = mem_data;
  assign ifa.rd_ready = rd_ready;
  assign ifb.rd_ready = rd_ready;
  assign ifc.rd_ready = rd_ready;

  retire_trace_buf #(.DEPTH(4), .OVERWRITE(1), .CAPTURE_NOP(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  retire_trace_buf #(.DEPTH(4), .OVERWRITE(0), .CAPTURE_NOP(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  retire_trace_buf #(.DEPTH(16), .OVERWRITE(1), .CAPTURE_NOP(1),
                     .WDOG_LIMIT(20))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic        o_valid [3];
  logic [31:0] o_level [3];
  logic [31:0] o_inst  [3];
  logic [31:0] o_cyc   [3];
  logic [31:0] o_drop  [3];
  logic        o_hlt   [3];
  logic        o_to    [3];
  logic        o_ovf   [3];
  ment_t       o_ent   [3];

  assign o_valid[0] = ifa.rd_valid;
  assign o_valid[1] = ifb.rd_valid;
  assign o_valid[2] = ifc.rd_valid;
  assign o_level[0] = 32'(ifa.level);
  assign o_level[1] = 32'(ifb.level);
  assign o_level[2] = 32'(ifc.level);
  assign o_inst[0] = ifa.inst_count;
  assign o_inst[1] = ifb.inst_count;
  assign o_inst[2] = ifc.inst_count;
  assign o_cyc[0] = ifa.cycle_count;
  assign o_cyc[1] = ifb.cycle_count;
  assign o_cyc[2] = ifc.cycle_count;
  assign o_drop[0] = ifa.drop_count;
  assign o_drop[1] = ifb.drop_count;
  assign o_drop[2] = ifc.drop_count;
  assign o_hlt[0] = ifa.halted;
  assign o_hlt[1] = ifb.halted;
  assign o_hlt[2] = ifc.halted;
  assign o_to[0] = ifa.timeout;
  assign o_to[1] = ifb.timeout;
  assign o_to[2] = ifc.timeout;
  assign o_ovf[0] = ifa.overflow;
  assign o_ovf[1] = ifb.overflow;
  assign o_ovf[2] = ifc.overflow;
  assign o_ent[0] = {ifa.rd_type, ifa.rd_inum, ifa.rd_pc,
                     ifa.rd_reg, ifa.rd_value, ifa.rd_addr};
  assign o_ent[1] = {ifb.rd_type, ifb.rd_inum, ifb.rd_pc,
                     ifb.rd_reg, ifb.rd_value, ifb.rd_addr};
  assign o_ent[2] = {ifc.rd_type, ifc.rd_inum, ifc.rd_pc,
                     ifc.rd_reg, ifc.rd_value, ifc.rd_addr};

  // model: per-config rules, state 0 idle, 1 run, 2 halted, 3 timeout
  int          cfg_depth [3] = '{4, 4, 16};
  bit          cfg_ow    [3] = '{1'b1, 1'b0, 1'b1};
  bit          cfg_cnop  [3] = '{1'b0, 1'b0, 1'b1};
  int unsigned cfg_wlim  [3] = '{100000, 100000, 20};
  int          m_st   [3];
  int unsigned m_inst [3];
  int unsigned m_cyc  [3];
  int unsigned m_drop [3];
  bit          m_ovf  [3];
  ment_t       mq [3][$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ment_t classify();
    ment_t e;
    e = '0;
    e.pc = pc;
    if (reg_write && mem_read) begin
      e.typ = 3'd1; e.rg = rd; e.val = wr_data; e.addr = mem_addr;
    end else if (reg_write) begin
      e.typ = 3'd0; e.rg = rd; e.val = wr_data;
    end else if (halt) begin
      e.typ = 3'd3;
    end else if (mem_write) begin
      e.typ = 3'd2; e.val = mem_data; e.addr = mem_addr;
    end else begin
      e.typ = 3'd4;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_inst[k] = 0; m_cyc[k] = 0;
      m_drop[k] = 0; m_ovf[k] = 1'b0;
      mq[k].delete();
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      ment_t e;
      if (rd_ready && mq[k].size() != 0) void'(mq[k].pop_front());
      if (m_st[k] == 0) begin
        if (en) m_st[k] = 1;
      end else if (m_st[k] == 1 && en) begin
        e = classify();
        m_cyc[k]++;
        if (e.typ != 3'd4 || cfg_cnop[k]) begin
          e.inum = m_inst[k];
          m_inst[k]++;
          if (mq[k].size() == cfg_depth[k]) begin
            m_ovf[k] = 1'b1;
            if (cfg_ow[k]) begin
              void'(mq[k].pop_front());
              mq[k].push_back(e);
            end else begin
              m_drop[k]++;
            end
          end else begin
            mq[k].push_back(e);
          end
        end
        if (e.typ == 3'd3) m_st[k] = 2;
        else if (m_cyc[k] == cfg_wlim[k]) m_st[k] = 3;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      ment_t h;
      chk($sformatf("valid%0d", k), o_valid[k], mq[k].size() != 0);
      chk($sformatf("level%0d", k), o_level[k], mq[k].size());
      chk($sformatf("inst%0d", k), o_inst[k], m_inst[k]);
      chk($sformatf("cycle%0d", k), o_cyc[k], m_cyc[k]);
      chk($sformatf("drop%0d", k), o_drop[k], m_drop[k]);
      chk($sformatf("ovf%0d", k), o_ovf[k], m_ovf[k]);
      chk($sformatf("halted%0d", k), o_hlt[k], m_st[k] == 2);
      chk($sformatf("timeout%0d", k), o_to[k], m_st[k] == 3);
      if (mq[k].size() != 0) begin
        h = mq[k][0];
        chk($sformatf("head%0d", k), o_ent[k], h);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(bit rw, bit mr, bit mw, bit h, logic [2:0] r,
                       logic [15:0] wd, logic [15:0] ma,
                       logic [15:0] md, logic [15:0] p);
    reg_write = rw; mem_read = mr; mem_write = mw; halt = h;
    rd = r; wr_data = wd; mem_addr = ma; mem_data = md; pc = p;
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      en       = $urandom_range(0, 9) != 0;
      rd_ready = $urandom_range(0, 1) != 0;
      drive($urandom_range(0, 9) < 4, $urandom_range(0, 1) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 2,
            3'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom));
      step();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rd_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    chk("rst_fields_a", o_ent[0], 0);
    chk("rst_fields_c", o_ent[2], 0);

    en = 1'b1;
    step();
    drive(1, 0, 0, 0, 3'd3, 16'h1234, 0, 0, 16'h0010);
    step();
    chk("alu_valid", o_valid[0], 1);
    chk("alu_type", o_ent[0].typ, 0);
    chk("alu_inum", o_ent[0].inum, 0);
    chk("alu_reg", o_ent[0].rg, 3);
    chk("alu_value", o_ent[0].val, 16'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0012);
    rd_ready = 1'b1;
    step();
    chk("pop_valid", o_valid[0], 0);
    chk("pop_inst", o_inst[0], 1);

    rd_ready = 1'b0;
    drive(1, 1, 0, 0, 3'd5, 16'hBEEF, 16'h0040, 0, 16'h0014);
    step();
    chk("load_type", o_ent[0].typ, 1);
    chk("load_addr", o_ent[0].addr, 16'h0040);
    chk("load_value", o_ent[0].val, 16'hBEEF);
    rd_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0016);
    step();
    rd_ready = 1'b0;
    drive(0, 0, 1, 0, 3'd6, 16'h7777, 16'h0080, 16'h55AA, 16'h0018);
    step();
    chk("store_type", o_ent[0].typ, 2);
    chk("store_value", o_ent[0].val, 16'h55AA);
    chk("store_reg", o_ent[0].rg, 0);
    rd_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h001A);
    step();

    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 3'(i), 16'(i + 100), 0, 0, 16'(32 + 2 * i));
      step();
    end
    chk("full_level", o_level[0], 4);
    chk("full_ovf", o_ovf[0], 0);
    rd_ready = 1'b1;
    drive(1, 0, 0, 0, 3'd7, 16'h0AAA, 0, 0, 16'h0040);
    step();
    chk("pushpop_level_a", o_level[0], 4);
    chk("pushpop_ovf_a", o_ovf[0], 0);
    chk("pushpop_level_b", o_level[1], 4);
    chk("pushpop_ovf_b", o_ovf[1], 0);
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 3'd1, 16'(200 + i), 0, 0, 16'(66 + 2 * i));
      step();
    end
    chk("ow_level", o_level[0], 4);
    chk("ow_ovf", o_ovf[0], 1);
    chk("drop_count", o_drop[1], 2);
    chk("drop_ovf", o_ovf[1], 1);
    rd_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0050);
    for (int i = 0; i < 4; i++) begin
      chk("ow_inum", o_ent[0].inum, 6 + i);
      chk("drop_inum", o_ent[1].inum, 4 + i);
      step();
    end
    repeat (5) step();
    chk("nop_level", o_level[0], 0);
    chk("wdog_timeout", o_to[2], 1);
    chk("wdog_cycles", o_cyc[2], 20);

    rd_ready = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h0070);
    step();
    chk("halt_flag", o_hlt[0], 1);
    chk("halt_type", o_ent[0].typ, 3);
    chk("halt_pc", o_ent[0].pc, 16'h0070);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 3'd2, 16'(i), 0, 0, 16'(16'h72 + i));
      step();
    end
    chk("halt_ignore_level", o_level[0], 1);
    chk("halt_ignore_inst", o_inst[0], 11);

    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("arst_level", o_level[0], 0);
    chk("arst_halted", o_hlt[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    rand_run(250);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    rand_run(250);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
